// File: rtl/threshold_segmenter.sv
// threshold_segmenter: multi-channel energy-triggered segmenter.
// Frames of NUM_CH signed samples are scored by energy (sum of squares) and kept in a
// pre-trigger ring. A frame at or above THRESHOLD_ON starts a segment: the ring is
// flushed oldest-first, then live frames pass straight through until HOLD_FRAMES quiet
// frames in a row or MAX_FRAMES total end the segment.
module threshold_segmenter #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned SAMPLE_W        = 16,
    parameter int unsigned ENERGY_W        = 34,
    parameter int unsigned PRE_DEPTH_INDEX = 4,
    parameter logic [31:0] THRESHOLD_ON    = 32'h0002_0000,
    parameter logic [31:0] THRESHOLD_OFF   = 32'h0001_0000,
    parameter int unsigned HOLD_FRAMES     = 4,
    parameter int unsigned MAX_FRAMES      = 100
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_vld,
    input  logic [NUM_CH*SAMPLE_W-1:0] frame_data,
    output logic                       frame_rdy,
    output logic                       transmit_vld,
    output logic [NUM_CH*SAMPLE_W-1:0] transmit_data,
    output logic                       transmit_last,
    input  logic                       transmit_rdy,
    output logic                       read_start_intr,
    output logic                       busy,
    output logic [15:0]                segment_len
);

    localparam int unsigned FrameW = NUM_CH * SAMPLE_W;
    localparam int unsigned Depth  = 2 ** PRE_DEPTH_INDEX;
    localparam int unsigned PtrW   = PRE_DEPTH_INDEX;
    localparam int unsigned CntW   = PRE_DEPTH_INDEX + 1;

    localparam logic [CntW-1:0]     CountFull = CntW'(Depth);
    localparam logic [CntW-1:0]     CntOne    = CntW'(1);
    localparam logic [PtrW-1:0]     PtrOne    = PtrW'(1);
    localparam logic [15:0]         SegOne    = 16'd1;
    localparam logic [15:0]         HoldLast  = 16'(HOLD_FRAMES - 1);
    localparam logic [15:0]         MaxLast   = 16'(MAX_FRAMES - 1);
    localparam logic [ENERGY_W-1:0] OnThr     = ENERGY_W'(THRESHOLD_ON);
    localparam logic [ENERGY_W-1:0] OffThr    = ENERGY_W'(THRESHOLD_OFF);

    typedef enum logic [1:0] {StIdle, StFlush, StLive} state_e;

    state_e              r_state, w_state_nxt;
    logic [FrameW-1:0]   r_ring [Depth];
    logic [PtrW-1:0]     r_wr_ptr, w_wr_ptr_nxt;
    logic [PtrW-1:0]     r_rd_ptr, w_rd_ptr_nxt;
    logic [CntW-1:0]     r_count, w_count_nxt;
    logic [CntW-1:0]     r_flush, w_flush_nxt;
    logic [15:0]         r_seg, w_seg_nxt;
    logic [15:0]         r_quiet, w_quiet_nxt;
    logic [15:0]         r_seg_len, w_seg_len_nxt;
    logic                r_intr, w_intr_nxt;

    logic                          w_ring_we;
    logic [CntW-1:0]               w_count_post;
    logic [ENERGY_W-1:0]           w_energy;
    logic signed [SAMPLE_W-1:0]    w_sample;
    logic signed [2*SAMPLE_W-1:0]  w_sample_ext;
    logic signed [2*SAMPLE_W-1:0]  w_square;
    logic                          w_quiet;
    logic                          w_hot;
    logic                          w_live_last;

    // Frame energy: sum of per-channel squares, always non-negative.
    always_comb begin
        w_energy     = '0;
        w_sample     = '0;
        w_sample_ext = '0;
        w_square     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_sample     = $signed(frame_data[k*SAMPLE_W +: SAMPLE_W]);
            w_sample_ext = {{SAMPLE_W{w_sample[SAMPLE_W-1]}}, w_sample};
            w_square     = w_sample_ext * w_sample_ext;
            w_energy     = w_energy + ENERGY_W'($unsigned(w_square));
        end
    end

    assign w_quiet = (w_energy < OffThr);
    assign w_hot   = (w_energy >= OnThr);

    // Quiet-hold and max-length end conditions share one last flag.
    assign w_live_last = (w_quiet && (r_quiet == HoldLast)) || (r_seg == MaxLast);

    assign w_count_post = (r_count == CountFull) ? r_count : (r_count + CntOne);

    // Next-state and output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_count_nxt   = r_count;
        w_flush_nxt   = r_flush;
        w_seg_nxt     = r_seg;
        w_quiet_nxt   = r_quiet;
        w_seg_len_nxt = r_seg_len;
        w_intr_nxt    = 1'b0;
        w_ring_we     = 1'b0;
        frame_rdy     = 1'b0;
        transmit_vld  = 1'b0;
        transmit_data = '0;
        transmit_last = 1'b0;
        unique case (r_state)
            StIdle: begin
                frame_rdy = 1'b1;
                if (frame_vld) begin
                    w_ring_we    = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + PtrOne;
                    w_count_nxt  = w_count_post;
                    if (w_hot) begin
                        // Oldest valid entry; a full ring wraps to the slot after the write.
                        w_rd_ptr_nxt = r_wr_ptr + PtrOne - PtrW'(w_count_post);
                        w_flush_nxt  = w_count_post;
                        w_seg_nxt    = '0;
                        w_intr_nxt   = 1'b1;
                        w_state_nxt  = StFlush;
                    end
                end
            end
            StFlush: begin
                transmit_vld  = 1'b1;
                transmit_data = r_ring[r_rd_ptr];
                if (transmit_rdy) begin
                    w_rd_ptr_nxt = r_rd_ptr + PtrOne;
                    w_seg_nxt    = r_seg + SegOne;
                    w_flush_nxt  = r_flush - CntOne;
                    if (r_flush == CntOne) begin
                        w_quiet_nxt = '0;
                        w_state_nxt = StLive;
                    end
                end
            end
            StLive: begin
                frame_rdy     = transmit_rdy;
                transmit_vld  = frame_vld;
                transmit_data = frame_data;
                transmit_last = w_live_last;
                if (frame_vld && transmit_rdy) begin
                    w_quiet_nxt = w_quiet ? (r_quiet + SegOne) : '0;
                    w_seg_nxt   = r_seg + SegOne;
                    if (w_live_last) begin
                        w_seg_len_nxt = r_seg + SegOne;
                        // Drop pre-trigger history so it never leaks into the next segment.
                        w_count_nxt   = '0;
                        w_state_nxt   = StIdle;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_flush   <= '0;
            r_seg     <= '0;
            r_quiet   <= '0;
            r_seg_len <= '0;
            r_intr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_count   <= w_count_nxt;
            r_flush   <= w_flush_nxt;
            r_seg     <= w_seg_nxt;
            r_quiet   <= w_quiet_nxt;
            r_seg_len <= w_seg_len_nxt;
            r_intr    <= w_intr_nxt;
        end
    end

    // Ring storage; contents beyond count are never read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_ring_we) begin
            r_ring[r_wr_ptr] <= frame_data;
        end
    end

    assign busy            = (r_state != StIdle);
    assign read_start_intr = r_intr;
    assign segment_len     = r_seg_len;

endmodule

// File: tb/tb_threshold_segmenter.sv
// Directed table-driven bench for threshold_segmenter (depth 4, ON 1000, OFF 500,
// HOLD 2, MAX 10). Each table row is one clock cycle of stimulus plus expected outputs.
module tb_threshold_segmenter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_vld = 1'b0;
    logic [63:0] frame_data = '0;
    logic        frame_rdy;
    logic        transmit_vld;
    logic [63:0] transmit_data;
    logic        transmit_last;
    logic        transmit_rdy = 1'b1;
    logic        read_start_intr;
    logic        busy;
    logic [15:0] segment_len;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    threshold_segmenter #(
        .NUM_CH         (4),
        .SAMPLE_W       (16),
        .ENERGY_W       (34),
        .PRE_DEPTH_INDEX(2),
        .THRESHOLD_ON   (32'd1000),
        .THRESHOLD_OFF  (32'd500),
        .HOLD_FRAMES    (2),
        .MAX_FRAMES     (10)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_vld      (frame_vld),
        .frame_data     (frame_data),
        .frame_rdy      (frame_rdy),
        .transmit_vld   (transmit_vld),
        .transmit_data  (transmit_data),
        .transmit_last  (transmit_last),
        .transmit_rdy   (transmit_rdy),
        .read_start_intr(read_start_intr),
        .busy           (busy),
        .segment_len    (segment_len)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic        rdy;
        logic [63:0] din;
        logic        e_frdy;
        logic        e_tvld;
        logic [63:0] e_data;
        logic        e_last;
        logic        e_intr;
        logic        e_busy;
        logic [15:0] e_len;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] fr(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic add(input logic rst, input logic vld, input logic rdy, input logic [63:0] din,
                       input logic efrdy, input logic etvld, input logic [63:0] edat,
                       input logic elast, input logic eintr, input logic ebusy,
                       input logic [15:0] elen);
        vec_t v;
        v.rst = rst; v.vld = vld; v.rdy = rdy; v.din = din;
        v.e_frdy = efrdy; v.e_tvld = etvld; v.e_data = edat; v.e_last = elast;
        v.e_intr = eintr; v.e_busy = ebusy; v.e_len = elen;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic vld, input logic [63:0] din, input logic [15:0] len);
        add(1'b1, vld, 1'b1, din, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, len);
    endtask

    task automatic flush(input logic [63:0] dat, input logic intr, input logic rdy,
                         input logic [15:0] len);
        add(1'b1, 1'b0, rdy, '0, 1'b0, 1'b1, dat, 1'b0, intr, 1'b1, len);
    endtask

    task automatic live(input logic [63:0] din, input logic rdy, input logic last,
                        input logic [15:0] len);
        add(1'b1, 1'b1, rdy, din, rdy, 1'b1, din, last, 1'b0, 1'b1, len);
    endtask

    task automatic rst_row(input logic [63:0] din);
        add(1'b0, 1'b1, 1'b1, din, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        rst_n        = v.rst;
        frame_vld    = v.vld;
        transmit_rdy = v.rdy;
        frame_data   = v.din;
        #1;
        if (v.rst) chk("frame_rdy", idx, 64'(frame_rdy), 64'(v.e_frdy));
        chk("transmit_vld", idx, 64'(transmit_vld), 64'(v.e_tvld));
        chk("transmit_last", idx, 64'(transmit_last), 64'(v.e_last));
        chk("read_start_intr", idx, 64'(read_start_intr), 64'(v.e_intr));
        chk("busy", idx, 64'(busy), 64'(v.e_busy));
        chk("segment_len", idx, 64'(segment_len), 64'(v.e_len));
        if (v.e_tvld) chk("transmit_data", idx, transmit_data, v.e_data);
    endtask

    initial begin
        logic [63:0] z, a, b, h, l, c1, c2, c3;
        z  = '0;
        a  = fr(40, 0, 0, 0);    // 1600: triggers
        b  = fr(7, 0, 0, 0);     // 49: quiet
        h  = fr(20, 10, 10, 10); // 700: between thresholds
        l  = fr(20, 0, 0, 0);    // 400: quiet
        c1 = fr(1, 0, 0, 0);
        c2 = fr(2, 0, 0, 0);
        c3 = fr(3, 0, 0, 0);

        // Reset state
        rst_row(z); rst_row(z);

        // Full ring trigger, hysteresis end after two quiet frames
        for (int i = 0; i < 6; i++) idle(1'b1, z, 16'd0);
        idle(1'b1, a, 16'd0);
        flush(z, 1'b1, 1'b1, 16'd0); flush(z, 1'b0, 1'b1, 16'd0);
        flush(z, 1'b0, 1'b1, 16'd0); flush(a, 1'b0, 1'b1, 16'd0);
        live(a, 1'b1, 1'b0, 16'd0); live(a, 1'b1, 1'b0, 16'd0);
        live(z, 1'b1, 1'b0, 16'd0); live(z, 1'b1, 1'b1, 16'd0);
        idle(1'b0, z, 16'd8);

        // Short history after reset
        rst_row(z); rst_row(z);
        idle(1'b1, z, 16'd0); idle(1'b1, a, 16'd0);
        flush(z, 1'b1, 1'b1, 16'd0); flush(a, 1'b0, 1'b1, 16'd0);
        live(b, 1'b1, 1'b0, 16'd0); live(b, 1'b1, 1'b1, 16'd0);
        idle(1'b0, z, 16'd4);

        // MAX length, then immediate retrigger with a one-frame flush
        for (int i = 0; i < 3; i++) idle(1'b1, z, 16'd4);
        idle(1'b1, a, 16'd4);
        flush(z, 1'b1, 1'b1, 16'd4); flush(z, 1'b0, 1'b1, 16'd4);
        flush(z, 1'b0, 1'b1, 16'd4); flush(a, 1'b0, 1'b1, 16'd4);
        for (int i = 0; i < 5; i++) live(a, 1'b1, 1'b0, 16'd4);
        live(a, 1'b1, 1'b1, 16'd4);
        idle(1'b1, a, 16'd10);
        flush(a, 1'b1, 1'b1, 16'd10);
        live(z, 1'b1, 1'b0, 16'd10); live(z, 1'b1, 1'b1, 16'd10);
        idle(1'b0, z, 16'd3);

        // Hysteresis: mid-band energy resets the quiet run
        idle(1'b1, a, 16'd3);
        flush(a, 1'b1, 1'b1, 16'd3);
        live(h, 1'b1, 1'b0, 16'd3); live(l, 1'b1, 1'b0, 16'd3);
        live(h, 1'b1, 1'b0, 16'd3); live(l, 1'b1, 1'b0, 16'd3);
        live(l, 1'b1, 1'b1, 16'd3);
        idle(1'b0, z, 16'd6);

        // Backpressure in FLUSH and LIVE
        idle(1'b1, c1, 16'd6); idle(1'b1, c2, 16'd6);
        idle(1'b1, c3, 16'd6); idle(1'b1, a, 16'd6);
        flush(c1, 1'b1, 1'b1, 16'd6);
        for (int i = 0; i < 5; i++) flush(c2, 1'b0, 1'b0, 16'd6);
        flush(c2, 1'b0, 1'b1, 16'd6); flush(c3, 1'b0, 1'b1, 16'd6);
        flush(a, 1'b0, 1'b1, 16'd6);
        live(h, 1'b1, 1'b0, 16'd6); live(l, 1'b0, 1'b0, 16'd6);
        live(l, 1'b1, 1'b0, 16'd6); live(l, 1'b0, 1'b1, 16'd6);
        live(l, 1'b1, 1'b1, 16'd6);
        idle(1'b0, z, 16'd7);

        // Reset mid-LIVE, then a clean one-frame segment
        idle(1'b1, a, 16'd7);
        flush(a, 1'b1, 1'b1, 16'd7);
        live(a, 1'b1, 1'b0, 16'd7);
        rst_row(a); rst_row(a);
        idle(1'b1, a, 16'd0);
        flush(a, 1'b1, 1'b1, 16'd0);
        live(z, 1'b1, 1'b0, 16'd0); live(z, 1'b1, 1'b1, 16'd0);
        idle(1'b0, z, 16'd3);

        foreach (tbl[i]) apply(tbl[i], i);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
